// File: rtl/lcd_seq_ctrl.sv
// rtl/lcd_seq_ctrl.sv - LCD power-up, init ROM streaming and window fill sequencer
module lcd_seq_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int INIT_LEN   = 107,
  parameter int H_RES      = 240,
  parameter int V_RES      = 240,
  parameter int RST_CYCLES = 1000,
  parameter int DELAY_UNIT = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [9:0]            rom_data,
  input  logic                  clear_req,
  input  logic [15:0]           clear_color,
  output logic                  clear_ack,
  input  logic                  draw_req,
  input  logic [8:0]            draw_x0,
  input  logic [8:0]            draw_x1,
  input  logic [8:0]            draw_y0,
  input  logic [8:0]            draw_y1,
  input  logic [15:0]           draw_color,
  output logic                  draw_ack,
  output logic                  wr_valid,
  output logic                  wr_dc,
  output logic [7:0]            wr_data,
  input  logic                  wr_ready,
  output logic                  lcd_rst_n,
  output logic                  init_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int CNT_MAX = (DLY_MAX > RST_CYCLES) ? DLY_MAX : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PIX_W   = 20;

  typedef enum logic [2:0] {S_OFF, S_RST_LO, S_RST_HI, S_INIT, S_IDLE, S_WIN, S_PIX} state_t;
  // INIT sub-phase: FETCH gives the synchronous ROM its one cycle, USE consumes rom_data
  typedef enum logic [1:0] {I_FETCH, I_USE, I_DELAY, I_DRAIN} init_t;

  state_t                state_q, state_d;
  init_t                 ist_q, ist_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  wr_dc_q, wr_dc_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  clear_ack_q, clear_ack_d;
  logic                  draw_ack_q, draw_ack_d;
  logic                  err_q, err_d;
  logic [8:0]            x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [15:0]           color_q, color_d;
  logic [3:0]            bidx_q, bidx_d;
  logic                  hi_out_q, hi_out_d;
  logic [PIX_W-1:0]      pix_left_q, pix_left_d;

  logic                  accept, slot_free, rom_last, draw_bad, init_adv, enter_win;
  logic                  win_dc;
  logic [7:0]            win_data;
  logic [9:0]            win_w, win_h;
  logic [PIX_W-1:0]      pix_total;

  assign accept    = wr_valid_q & wr_ready;
  assign slot_free = ~wr_valid_q | wr_ready;
  assign rom_last  = (rom_addr_q == ADDR_WIDTH'(INIT_LEN - 1));
  assign draw_bad  = (draw_x0 > draw_x1) || (draw_y0 > draw_y1) ||
                     ({1'b0, draw_x1} >= 10'(H_RES)) || ({1'b0, draw_y1} >= 10'(V_RES));
  assign win_w     = {1'b0, x1_q} - {1'b0, x0_q} + 10'd1;
  assign win_h     = {1'b0, y1_q} - {1'b0, y0_q} + 10'd1;
  assign pix_total = PIX_W'(win_w) * PIX_W'(win_h);

  // Window-set byte selected by bidx_q; index 0 (0x2A) is preloaded on WIN entry
  always_comb begin
    win_dc   = 1'b1;
    win_data = 8'h00;
    case (bidx_q)
      4'd0:    begin win_dc = 1'b0; win_data = 8'h2A; end
      4'd1:    win_data = {7'd0, x0_q[8]};
      4'd2:    win_data = x0_q[7:0];
      4'd3:    win_data = {7'd0, x1_q[8]};
      4'd4:    win_data = x1_q[7:0];
      4'd5:    begin win_dc = 1'b0; win_data = 8'h2B; end
      4'd6:    win_data = {7'd0, y0_q[8]};
      4'd7:    win_data = y0_q[7:0];
      4'd8:    win_data = {7'd0, y1_q[8]};
      4'd9:    win_data = y1_q[7:0];
      4'd10:   begin win_dc = 1'b0; win_data = 8'h2C; end
      default: begin win_dc = 1'b1; win_data = 8'h00; end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_OFF;
      ist_q       <= I_FETCH;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      wr_valid_q  <= 1'b0;
      wr_dc_q     <= 1'b0;
      wr_data_q   <= 8'h00;
      clear_ack_q <= 1'b0;
      draw_ack_q  <= 1'b0;
      err_q       <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      bidx_q      <= '0;
      hi_out_q    <= 1'b0;
      pix_left_q  <= '0;
    end else begin
      state_q     <= state_d;
      ist_q       <= ist_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_dc_q     <= wr_dc_d;
      wr_data_q   <= wr_data_d;
      clear_ack_q <= clear_ack_d;
      draw_ack_q  <= draw_ack_d;
      err_q       <= err_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      bidx_q      <= bidx_d;
      hi_out_q    <= hi_out_d;
      pix_left_q  <= pix_left_d;
    end
  end

  // Next state, byte register loading and request arbitration
  always_comb begin
    state_d     = state_q;
    ist_d       = ist_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    wr_valid_d  = wr_valid_q & ~wr_ready;
    wr_dc_d     = wr_dc_q;
    wr_data_d   = wr_data_q;
    clear_ack_d = 1'b0;
    draw_ack_d  = 1'b0;
    err_d       = 1'b0;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    color_d     = color_q;
    bidx_d      = bidx_q;
    hi_out_d    = hi_out_q;
    pix_left_d  = pix_left_q;
    init_adv    = 1'b0;
    enter_win   = 1'b0;

    case (state_q)
      S_OFF: begin
        if (start) begin
          state_d = S_RST_LO;
          cnt_d   = CNT_W'(RST_CYCLES);
        end
      end
      S_RST_LO: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RST_HI;
          cnt_d   = CNT_W'(RST_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RST_HI: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = S_INIT;
          ist_d      = I_FETCH;
          rom_addr_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_INIT: begin
        case (ist_q)
          I_FETCH: ist_d = I_USE;
          I_USE: begin
            // rom_addr is held while the byte slot is busy, so rom_data stays valid
            if (slot_free) begin
              if (!rom_data[9]) begin
                wr_valid_d = 1'b1;
                wr_dc_d    = rom_data[8];
                wr_data_d  = rom_data[7:0];
                init_adv   = 1'b1;
              end else if (rom_data[7:0] == 8'd0) begin
                init_adv = 1'b1;
              end else begin
                cnt_d = CNT_W'(32'(rom_data[7:0]) * DELAY_UNIT);
                ist_d = I_DELAY;
              end
            end
          end
          I_DELAY: begin
            if (cnt_q <= CNT_W'(1)) init_adv = 1'b1;
            else                    cnt_d    = cnt_q - CNT_W'(1);
          end
          default: begin
            if (slot_free) state_d = S_IDLE;
          end
        endcase
        if (init_adv) begin
          if (rom_last) begin
            ist_d = I_DRAIN;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
            ist_d      = I_FETCH;
          end
        end
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_RST_LO;
          cnt_d   = CNT_W'(RST_CYCLES);
        end else if (!clear_ack_q && !draw_ack_q) begin
          // Skip the ack cycle: the requester still holds its level until it sees the ack
          if (clear_req) begin
            clear_ack_d = 1'b1;
            x0_d        = '0;
            x1_d        = 9'(H_RES - 1);
            y0_d        = '0;
            y1_d        = 9'(V_RES - 1);
            color_d     = clear_color;
            enter_win   = 1'b1;
          end else if (draw_req) begin
            draw_ack_d = 1'b1;
            if (draw_bad) begin
              err_d = 1'b1;
            end else begin
              x0_d      = draw_x0;
              x1_d      = draw_x1;
              y0_d      = draw_y0;
              y1_d      = draw_y1;
              color_d   = draw_color;
              enter_win = 1'b1;
            end
          end
        end
        if (enter_win) begin
          state_d    = S_WIN;
          wr_valid_d = 1'b1;
          wr_dc_d    = 1'b0;
          wr_data_d  = 8'h2A;
          bidx_d     = 4'd1;
        end
      end
      S_WIN: begin
        if (accept) begin
          wr_valid_d = 1'b1;
          if (bidx_q == 4'd11) begin
            state_d    = S_PIX;
            wr_dc_d    = 1'b1;
            wr_data_d  = color_q[15:8];
            hi_out_d   = 1'b1;
            pix_left_d = pix_total - PIX_W'(1);
          end else begin
            wr_dc_d   = win_dc;
            wr_data_d = win_data;
            bidx_d    = bidx_q + 4'd1;
          end
        end
      end
      S_PIX: begin
        if (accept) begin
          if (hi_out_q) begin
            wr_valid_d = 1'b1;
            wr_data_d  = color_q[7:0];
            hi_out_d   = 1'b0;
          end else if (pix_left_q == '0) begin
            state_d = S_IDLE;
          end else begin
            wr_valid_d = 1'b1;
            wr_data_d  = color_q[15:8];
            hi_out_d   = 1'b1;
            pix_left_d = pix_left_q - PIX_W'(1);
          end
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    lcd_rst_n = ~((state_q == S_OFF) || (state_q == S_RST_LO));
    init_done = (state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_PIX);
    busy      = ~((state_q == S_OFF) || (state_q == S_IDLE));
    done      = (state_q == S_PIX) && accept && !hi_out_q && (pix_left_q == '0);
  end

  assign rom_addr  = rom_addr_q;
  assign wr_valid  = wr_valid_q;
  assign wr_dc     = wr_dc_q;
  assign wr_data   = wr_data_q;
  assign clear_ack = clear_ack_q;
  assign draw_ack  = draw_ack_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb/tb_lcd_seq_ctrl.sv - scoreboard and vector-table bench for lcd_seq_ctrl
module tb_lcd_seq_ctrl;

  localparam int AW         = 17;
  localparam int INIT_LEN   = 5;
  localparam int H_RES      = 16;
  localparam int V_RES      = 12;
  localparam int RST_CYCLES = 20;
  localparam int DELAY_UNIT = 10;

  logic          clk = 1'b0;
  logic          rstn, start, clear_req, draw_req, wr_ready;
  logic [AW-1:0] rom_addr;
  logic [9:0]    rom_data;
  logic [15:0]   clear_color, draw_color;
  logic [8:0]    draw_x0, draw_x1, draw_y0, draw_y1;
  logic          clear_ack, draw_ack, wr_valid, wr_dc, lcd_rst_n, init_done, busy, done, err;
  logic [7:0]    wr_data;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  bit log_acc  = 0;
  bit rand_ready = 0;
  int acc_t[$];
  logic [8:0] exp_q[$];
  logic [9:0] rom [0:4];

  typedef struct {
    int         x0, x1, y0, y1;
    logic [15:0] c;
    bit         bad;
    bit         rnd;
  } vec_t;
  vec_t vt[9];

  lcd_seq_ctrl #(
    .ADDR_WIDTH(AW), .INIT_LEN(INIT_LEN), .H_RES(H_RES), .V_RES(V_RES),
    .RST_CYCLES(RST_CYCLES), .DELAY_UNIT(DELAY_UNIT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .clear_req(clear_req), .clear_color(clear_color), .clear_ack(clear_ack),
    .draw_req(draw_req), .draw_x0(draw_x0), .draw_x1(draw_x1), .draw_y0(draw_y0),
    .draw_y1(draw_y1), .draw_color(draw_color), .draw_ack(draw_ack),
    .wr_valid(wr_valid), .wr_dc(wr_dc), .wr_data(wr_data), .wr_ready(wr_ready),
    .lcd_rst_n(lcd_rst_n), .init_done(init_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= (rom_addr < 17'd5) ? rom[rom_addr[2:0]] : 10'h000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Byte handshake monitor: scoreboard pop, stall stability, done/err counting
  initial begin
    logic [9:0] hold_byte;
    logic [8:0] e;
    bit holding;
    holding = 0;
    hold_byte = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        holding = 0;
      end else begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (holding) chk("stall_stable", {wr_valid, wr_dc, wr_data}, hold_byte);
        holding = 0;
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: actual=%0h expected=none", {wr_dc, wr_data});
          end else begin
            e = exp_q.pop_front();
            chk("wr_byte", {wr_dc, wr_data}, e);
          end
          if (log_acc) acc_t.push_back(cyc);
        end else if (wr_valid) begin
          holding = 1;
          hold_byte = {1'b1, wr_dc, wr_data};
        end
      end
    end
  end

  // wr_ready driver: constant 1 or pseudo-random backpressure
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_op(input int x0, input int x1, input int y0, input int y1, input logic [15:0] c);
    int n;
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'(x0 >> 8)});
    exp_q.push_back({1'b1, 8'(x0 & 255)});
    exp_q.push_back({1'b1, 8'(x1 >> 8)});
    exp_q.push_back({1'b1, 8'(x1 & 255)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'(y0 >> 8)});
    exp_q.push_back({1'b1, 8'(y0 & 255)});
    exp_q.push_back({1'b1, 8'(y1 >> 8)});
    exp_q.push_back({1'b1, 8'(y1 & 255)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_dc", wr_dc, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_lcd_rst_n", lcd_rst_n, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_clear_ack", clear_ack, 0);
    chk("rst_draw_ack", draw_ack, 0);
  endtask

  task automatic wait_ack(input bit is_clear, input int budget, output bit seen, output bit e_at);
    seen = 0;
    e_at = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (is_clear ? clear_ack : draw_ack) begin
        seen = 1;
        e_at = err;
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({name, "_seen"}, seen, 1);
    if (seen) begin
      @(negedge clk);
      chk({name, "_idle_next"}, busy, 0);
      chk({name, "_init_done"}, init_done, 1);
    end
  endtask

  task automatic do_init();
    int lo_n, hi_n;
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h122);
    exp_q.push_back(9'h133);
    exp_q.push_back(9'h029);
    acc_t.delete();
    log_acc = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_init_done_low", init_done, 0);
    lo_n = 0;
    hi_n = 0;
    for (int k = 0; k < 2000 && !init_done; k++) begin
      @(negedge clk);
      if (busy && !lcd_rst_n) lo_n++;
      if (lcd_rst_n && !wr_valid && acc_t.size() == 0) hi_n++;
    end
    chk("rst_lo_len", lo_n, RST_CYCLES);
    chk("rst_hi_len_ok", (hi_n >= RST_CYCLES) && (hi_n <= RST_CYCLES + 3), 1);
    chk("init_done", init_done, 1);
    chk("init_busy", busy, 0);
    chk("init_byte_count", acc_t.size(), 4);
    if (acc_t.size() == 4) begin
      chk("init_delay_gap_ok", (acc_t[3] - acc_t[2] >= 2 * DELAY_UNIT) &&
                               (acc_t[3] - acc_t[2] <= 2 * DELAY_UNIT + 8), 1);
      chk("init_b2b_ok", (acc_t[1] - acc_t[0] <= 3) && (acc_t[2] - acc_t[1] <= 3), 1);
    end
    chk("init_q_empty", exp_q.size(), 0);
    log_acc = 0;
  endtask

  task automatic run_draw(input vec_t v);
    bit seen, e_at;
    int d0, e0, wv;
    d0 = done_cnt;
    e0 = err_cnt;
    if (!v.bad) push_op(v.x0, v.x1, v.y0, v.y1, v.c);
    rand_ready = v.rnd;
    @(posedge clk); #1;
    draw_x0 = 9'(v.x0); draw_x1 = 9'(v.x1);
    draw_y0 = 9'(v.y0); draw_y1 = 9'(v.y1);
    draw_color = v.c;
    draw_req = 1'b1;
    wait_ack(1'b0, 50, seen, e_at);
    chk("draw_ack_seen", seen, 1);
    chk("err_with_ack", e_at, v.bad);
    @(posedge clk); #1 draw_req = 1'b0;
    if (v.bad) begin
      wv = 0;
      repeat (20) begin
        @(negedge clk);
        if (wr_valid || busy) wv++;
      end
      chk("bad_no_bytes_idle", wv, 0);
      chk("bad_no_done", done_cnt, d0);
      chk("bad_err_once", err_cnt, e0 + 1);
    end else begin
      wait_done("draw_done", 5000);
      repeat (2) @(negedge clk);
      chk("draw_done_once", done_cnt, d0 + 1);
      chk("draw_q_empty", exp_q.size(), 0);
      chk("draw_no_err", err_cnt, e0);
    end
    rand_ready = 0;
  endtask

  initial begin
    bit seen, e_at;
    int d0;
    rom[0] = 10'h011;
    rom[1] = 10'h122;
    rom[2] = 10'h133;
    rom[3] = {2'b10, 8'd2};
    rom[4] = 10'h029;

    vt[0] = '{10, 11, 5, 6, 16'hF800, 1'b0, 1'b0};
    vt[1] = '{0, 0, 0, 0, 16'h1234, 1'b0, 1'b0};
    vt[2] = '{15, 15, 11, 11, 16'hABCD, 1'b0, 1'b0};
    vt[3] = '{20, 10, 0, 0, 16'h1111, 1'b1, 1'b0};
    vt[4] = '{0, 16, 0, 0, 16'h2222, 1'b1, 1'b0};
    vt[5] = '{0, 0, 3, 2, 16'h3333, 1'b1, 1'b0};
    vt[6] = '{0, 0, 0, 12, 16'h4444, 1'b1, 1'b0};
    vt[7] = '{0, 15, 0, 11, 16'h5A5A, 1'b0, 1'b1};
    vt[8] = '{3, 5, 2, 2, 16'hC3E1, 1'b0, 1'b1};

    rstn = 1'b0; start = 1'b0; clear_req = 1'b0; draw_req = 1'b0;
    clear_color = '0; draw_color = '0;
    draw_x0 = '0; draw_x1 = '0; draw_y0 = '0; draw_y1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1 rstn = 1'b1;

    // power-up and init ROM replay
    do_init();

    // draw vector table, including invalid windows and backpressure
    for (int i = 0; i < 9; i++) run_draw(vt[i]);

    // clear and draw raised together: clear wins, draw stays pending
    d0 = done_cnt;
    push_op(0, H_RES - 1, 0, V_RES - 1, 16'h07E0);
    push_op(2, 4, 1, 3, 16'h001F);
    @(posedge clk); #1;
    clear_color = 16'h07E0;
    draw_x0 = 9'd2; draw_x1 = 9'd4; draw_y0 = 9'd1; draw_y1 = 9'd3;
    draw_color = 16'h001F;
    clear_req = 1'b1;
    draw_req  = 1'b1;
    wait_ack(1'b1, 50, seen, e_at);
    chk("clear_ack_seen", seen, 1);
    chk("draw_not_acked_with_clear", draw_ack, 0);
    @(posedge clk); #1 clear_req = 1'b0;
    wait_ack(1'b0, 3000, seen, e_at);
    chk("pending_draw_ack_seen", seen, 1);
    chk("clear_done_before_draw", done_cnt, d0 + 1);
    @(posedge clk); #1 draw_req = 1'b0;
    wait_done("pending_draw_done", 3000);
    chk("clear_draw_done_count", done_cnt, d0 + 2);
    chk("clear_draw_q_empty", exp_q.size(), 0);

    // reset in the middle of a pixel stream
    d0 = done_cnt;
    push_op(0, H_RES - 1, 0, V_RES - 1, 16'hAAAA);
    @(posedge clk); #1;
    draw_x0 = 9'd0; draw_x1 = 9'(H_RES - 1); draw_y0 = 9'd0; draw_y1 = 9'(V_RES - 1);
    draw_color = 16'hAAAA;
    draw_req = 1'b1;
    wait_ack(1'b0, 50, seen, e_at);
    chk("abort_draw_ack_seen", seen, 1);
    @(posedge clk); #1 draw_req = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_busy_mid_pix", busy, 1);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    check_reset_vals();
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_off_busy", busy, 0);
    chk("abort_off_rom_addr", rom_addr, 0);
    do_init();

    // start from IDLE forces a full re-init
    do_init();
    run_draw(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
